// File: rtl/wait_event_pkg.sv
// Shared types and helpers for the wait_event observer.
package wait_event_pkg;

    typedef enum logic [1:0] {
        RISE = 2'b00,
        FALL = 2'b01,
        HIGH = 2'b10,
        LOW  = 2'b11
    } wait_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        REPORT = 2'b10
    } wait_state_t;

    // Width of a selector able to address 'size' signals, never below one bit.
    function automatic int sel_w(input int size);
        return ($clog2(size) > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/wait_event_sync.sv
// Multi-stage resynchroniser bringing the observed DUT signals into the clk domain.
module wait_event_sync
    import wait_event_pkg::*;
#(
    parameter int WAIT_SIZE   = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WAIT_SIZE-1:0] d,
    output logic [WAIT_SIZE-1:0] q
);

    logic [WAIT_SIZE-1:0] stages [SYNC_STAGES];

    // Shift the raw inputs through the flop chain; cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/wait_event_tb.sv
// WAIT_EVENT observer: waits for an edge or level on a selected, resynchronised
// DUT signal with an optional cycle timeout and reports the outcome as pulses.
module wait_event_tb
    import wait_event_pkg::*;
#(
    parameter int WAIT_SIZE     = 5,
    parameter int TIMEOUT_WIDTH = 32,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WAIT_SIZE-1:0]        i_wait_signals_asynch,
    input  logic                        i_start,
    input  logic [sel_w(WAIT_SIZE)-1:0] i_sel,
    input  logic [1:0]                  i_mode,
    input  logic [TIMEOUT_WIDTH-1:0]    i_timeout,
    input  logic                        i_abort,
    output logic [WAIT_SIZE-1:0]        o_wait_signals_synch,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_timeout_err,
    output logic                        o_cfg_err,
    output logic [TIMEOUT_WIDTH-1:0]    o_elapsed
);

    localparam int SEL_W = sel_w(WAIT_SIZE);
    localparam logic [SEL_W:0] SIZE_L = WAIT_SIZE[SEL_W:0];

    wait_state_t             state_q, state_nxt;
    logic [SEL_W-1:0]        sel_q;
    wait_mode_t              mode_q;
    logic [TIMEOUT_WIDTH-1:0] timeout_q;
    logic [TIMEOUT_WIDTH-1:0] cnt_q;
    logic [TIMEOUT_WIDTH-1:0] cnt_inc;
    logic [TIMEOUT_WIDTH-1:0] elapsed_q;
    logic                    prev_q;
    logic                    done_q, tmo_q, cfg_q;
    logic [WAIT_SIZE-1:0]    synch;
    logic                    cur;
    logic                    hit;
    logic                    tmo_hit;
    logic                    sel_ok;

    wait_event_sync #(
        .WAIT_SIZE  (WAIT_SIZE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (i_wait_signals_asynch),
        .q    (synch)
    );

    assign o_wait_signals_synch = synch;
    assign sel_ok  = ({1'b0, i_sel} < SIZE_L);
    assign cur     = synch[sel_q];
    assign cnt_inc = cnt_q + 1'b1;
    assign tmo_hit = (timeout_q != '0) && (cnt_inc == timeout_q);

    // Edge/level comparator against the previous sample of the selected signal.
    always_comb begin
        hit = 1'b0;
        case (mode_q)
            RISE:    hit = !prev_q && cur;
            FALL:    hit = prev_q && !cur;
            HIGH:    hit = cur;
            LOW:     hit = !cur;
            default: hit = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic: abort beats event, event beats timeout.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (i_start && sel_ok) state_nxt = WAIT;
            WAIT: begin
                if (i_abort)               state_nxt = IDLE;
                else if (hit || tmo_hit)   state_nxt = REPORT;
            end
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch, evaluation counter, result pulses and elapsed count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q     <= '0;
            mode_q    <= RISE;
            timeout_q <= '0;
            cnt_q     <= '0;
            elapsed_q <= '0;
            prev_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            cfg_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
            cfg_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        if (sel_ok) begin
                            sel_q     <= i_sel;
                            mode_q    <= wait_mode_t'(i_mode);
                            timeout_q <= i_timeout;
                            prev_q    <= synch[i_sel];
                            cnt_q     <= '0;
                        end else begin
                            cfg_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    prev_q <= cur;
                    if (i_abort) begin
                        elapsed_q <= cnt_q;
                    end else if (hit) begin
                        done_q    <= 1'b1;
                        elapsed_q <= cnt_q;
                    end else if (tmo_hit) begin
                        tmo_q     <= 1'b1;
                        elapsed_q <= timeout_q;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        o_busy        = (state_q == WAIT);
        o_done        = done_q;
        o_timeout_err = tmo_q;
        o_cfg_err     = cfg_q;
        o_elapsed     = elapsed_q;
    end

endmodule

// File: tb/tb_wait_event_tb.sv
// Self-checking bench for wait_event_tb: vector table plus hand sequences,
// with a scoreboard queue of expected result pulses.
module tb_wait_event_tb;
    import wait_event_pkg::*;

    localparam int WS = 5;
    localparam int TW = 32;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WS-1:0] sig;
    logic          start;
    logic [2:0]    sel;
    logic [1:0]    mode;
    logic [TW-1:0] tmo;
    logic          abort;
    logic [WS-1:0] synch;
    logic          busy, done, tmo_err, cfg_err;
    logic [TW-1:0] elapsed;

    always #5 clk = ~clk;

    wait_event_tb #(
        .WAIT_SIZE    (WS),
        .TIMEOUT_WIDTH(TW),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_wait_signals_asynch(sig),
        .i_start              (start),
        .i_sel                (sel),
        .i_mode               (mode),
        .i_timeout            (tmo),
        .i_abort              (abort),
        .o_wait_signals_synch (synch),
        .o_busy               (busy),
        .o_done               (done),
        .o_timeout_err        (tmo_err),
        .o_cfg_err            (cfg_err),
        .o_elapsed            (elapsed)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int unsigned cyc = 0;
    logic [TW-1:0] last_el = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = done, 1 = timeout, 2 = cfg error
    typedef struct {
        int          kind;
        logic [TW-1:0] el;
        int unsigned at;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]    sel;
        logic [1:0]    mode;
        logic [TW-1:0] timeout;
        logic          pre;
        int            k;      // evaluation at which the new level is seen, 0 = never
        int            kind;
        logic [TW-1:0] el;
        int            eval;   // evaluation producing the pulse, 0 for cfg error
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pop the scoreboard whenever a result pulse appears.
    always @(negedge clk) begin
        exp_t e;
        if (done || tmo_err || cfg_err) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {61'd0, done, tmo_err, cfg_err}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_bits", {61'd0, done, tmo_err, cfg_err},
                      {61'd0, e.kind == 0, e.kind == 1, e.kind == 2});
                check("elapsed", 64'(elapsed), 64'(e.el));
                check("pulse_cycle", 64'(cyc), 64'(e.at));
                check("busy_at_pulse", 64'(busy), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2:0] s, input logic [1:0] m, input logic [TW-1:0] t);
        sel   = s;
        mode  = m;
        tmo   = t;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input int kind, input logic [TW-1:0] el, input int eval);
        exp_t e;
        e.kind = kind;
        e.el   = el;
        e.at   = cyc + 1 + eval;
        sb.push_back(e);
        last_el = el;
    endtask

    task automatic wait_resp(input int budget);
        int c = 0;
        while (sb.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        check("response_pending", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic apply(input vec_t v);
        int c = 0;
        sig = {WS{~v.pre}};
        if (int'(v.sel) < WS) sig[v.sel] = v.pre;
        repeat (4) tick();
        push(v.kind, (v.kind == 2) ? last_el : v.el, v.eval);
        do_start(v.sel, v.mode, v.timeout);
        while (sb.size() != 0 && c < 200) begin
            if (v.k >= 3 && c == v.k - 3) sig[v.sel] = ~v.pre;
            tick();
            c++;
        end
        check("response_pending", 64'(sb.size()), 64'd0);
        sb.delete();
        check("busy_after", 64'(busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            sel   mode   timeout pre  k   kind el     eval
        vecs[0] = '{3'd2, 2'b00, 32'd100, 1'b0, 11, 0, 32'd10, 11};
        vecs[1] = '{3'd0, 2'b10, 32'd50,  1'b1, 0,  0, 32'd0,  1};
        vecs[2] = '{3'd1, 2'b01, 32'd20,  1'b1, 0,  1, 32'd20, 20};
        vecs[3] = '{3'd3, 2'b00, 32'd5,   1'b0, 5,  0, 32'd4,  5};
        vecs[4] = '{3'd7, 2'b00, 32'd5,   1'b0, 0,  2, 32'd0,  0};
        vecs[5] = '{3'd5, 2'b10, 32'd9,   1'b1, 0,  2, 32'd0,  0};
        vecs[6] = '{3'd2, 2'b11, 32'd30,  1'b1, 4,  0, 32'd3,  4};
        vecs[7] = '{3'd1, 2'b01, 32'd40,  1'b1, 7,  0, 32'd6,  7};
        vecs[8] = '{3'd0, 2'b00, 32'd6,   1'b1, 0,  1, 32'd6,  6};
        vecs[9] = '{3'd4, 2'b10, 32'd3,   1'b0, 0,  1, 32'd3,  3};

        rst_n = 1'b0;
        sig   = '1;
        start = 1'b0;
        sel   = '0;
        mode  = '0;
        tmo   = '0;
        abort = 1'b0;

        // Reset state and sync-chain latency.
        repeat (3) tick();
        check("rst_synch",   64'(synch),   64'd0);
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_done",    64'(done),    64'd0);
        check("rst_tmo",     64'(tmo_err), 64'd0);
        check("rst_cfg",     64'(cfg_err), 64'd0);
        check("rst_elapsed", 64'(elapsed), 64'd0);
        rst_n = 1'b1;
        tick();
        check("synch_lat1", 64'(synch), 64'd0);
        tick();
        check("synch_lat2", 64'(synch), 64'h1f);

        // Table-driven waits.
        for (int i = 0; i < 10; i++) apply(vecs[i]);

        // Long forever-wait aborted after 1000 evaluations; start in WAIT ignored.
        sig = 5'b10000;
        repeat (4) tick();
        do_start(3'd4, 2'b11, 32'd0);
        check("abort_busy", 64'(busy), 64'd1);
        repeat (1000) tick();
        abort = 1'b1;
        start = 1'b1;
        sel   = 3'd3;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_idle",    64'(busy),    64'd0);
        check("abort_elapsed", 64'(elapsed), 64'd1000);
        last_el = 32'd1000;
        push(0, 32'd0, 1);
        do_start(3'd4, 2'b10, 32'd10);
        check("restart_busy", 64'(busy), 64'd1);
        wait_resp(20);

        // Abort in the same cycle as the event: no pulse, elapsed = 4.
        sig = 5'b11110;
        repeat (4) tick();
        do_start(3'd0, 2'b10, 32'd0);
        tick();
        tick();
        sig[0] = 1'b1;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_evt_busy",    64'(busy),    64'd0);
        check("abort_evt_elapsed", 64'(elapsed), 64'd4);
        repeat (4) tick();

        // Reset mid-wait: back to idle, no pulse.
        sig = 5'b00000;
        repeat (4) tick();
        do_start(3'd1, 2'b00, 32'd0);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy",    64'(busy),    64'd0);
        check("midrst_elapsed", 64'(elapsed), 64'd0);
        repeat (5) tick();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
